qrng_arbiter: RTL
=================

# qrng_arbiter

Shares one 8-bit maximal-length LFSR random source among `NUM_REQ` requesters in the FPGA background demo. Sequences the source through seeding and warm-up, then serves at most one requester per cycle. Requesters are picked round-robin. Each grant delivers a distinct consecutive LFSR value. Optional health checking rejects an all-zero seed and halts service until the source is re-seeded.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8)
- `WARMUP_CYCLES`, 16: LFSR advance steps after reset/seed before service (0 allowed)
- `SEED`, 8'hA5: reset seed and zero-seed substitute
- `clk` in 1: single clock, all logic on rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `seed_load` in 1: single-cycle pulse, reload LFSR from `seed_val`
- `seed_val` in 8: new seed, sampled when `seed_load`=1
- `req` in NUM_REQ: level request per requester, held until granted
- `gnt` out NUM_REQ: registered one-hot grant, one-cycle pulse
- `rnd_out` out 8: random value for the granted requester, valid with `rnd_valid`
- `rnd_valid` out 1: high exactly when `gnt` is non-zero
- `busy` out 1: state is not SERVE
- `stuck_err` out 1: sticky health fault (0 when health disabled)

## Operation
- LFSR: polynomial x^8+x^6+x^5+x^4+1. Each step is lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}. Sequence from A5 is A5→4A→95→2A→54.
- States: WARMUP, SERVE, FAULT (FAULT exists only with health enabled).
- Reset value: lfsr=SEED, state=WARMUP, warm-up counter=0, round-robin pointer=NUM_REQ-1, gnt=0, rnd_valid=0, rnd_out=0, stuck_err=0. `busy`=1 follows from the state.
- WARMUP: LFSR advances every edge. After exactly WARMUP_CYCLES advancing edges the block moves to SERVE. If WARMUP_CYCLES=0, it goes straight to SERVE and no advance occurs. No grants are issued.
- SERVE: LFSR advances every edge, whether or not a grant is issued.
  - Eligible requesters are `req` with the previous cycle's grant bit masked out. This covers a requester's req that is still high in its own grant cycle.
  - The grant goes to the first eligible index after the pointer, searching with wrap-around, and the pointer is updated to that index.
  - On the grant edge: gnt <= one-hot, rnd_out <= lfsr (pre-advance value), rnd_valid <= 1.
  - With no eligible requester: gnt=0, rnd_valid=0, and rnd_out holds its last value.
- Seed load has priority in any state. On a `seed_load` edge:
  - lfsr <= seed_val, or SEED if seed_val=0 and health is disabled.
  - Counter is cleared and state goes to WARMUP (or SERVE if WARMUP_CYCLES=0).
  - No grant is issued on that edge and the LFSR does not advance.
  - The round-robin pointer is kept.
- A requester drops `req` the cycle after it observes `gnt`, or keeps it high to request again. The same requester is served at most every second cycle; aggregate throughput is one grant per cycle.
- Reset asserted mid-operation returns everything to reset values immediately. Pending requests are not remembered.

## Timing
- Request-to-grant latency: `req` high in SERVE cycle t with the requester winning arbitration gives gnt/rnd_valid in cycle t+1.
- The first possible grant appears in the cycle after the first SERVE cycle.
- `busy` is decoded from the state register, with no extra latency.
- Consecutive grants carry consecutive LFSR values only if issued on consecutive cycles. Otherwise values are skipped, but never repeated within a period of 255.

## Configuration
- `QRNG_HEALTH_EN` defined:
  - A `seed_load` with seed_val=0 loads nothing, sets stuck_err=1 and enters FAULT.
  - FAULT also triggers if lfsr is ever 0 in SERVE.
  - In FAULT: no grants, LFSR frozen, busy=1.
  - Only a non-zero `seed_load` leaves FAULT; stuck_err clears only on reset.
- Undefined: zero seed is silently replaced by SEED, there is no FAULT state, and stuck_err is tied 0.

## Structure
- Package `qrng_pkg`: state enum, LFSR width (8), tap mask 8'hB8, default seed 8'hA5.
- Sub-module `qrng_lfsr8_core`: 8-bit LFSR with `load`/`load_val`/`step` inputs and `value` output.
- `qrng_arbiter` holds the FSM, warm-up counter, round-robin arbiter and output registers.

## Test plan
- WARMUP_CYCLES=2, reset released, req=4'b0100 held → busy=1 for 2 cycles, then the first grant gives gnt=4'b0100, rnd_out=8'h95, rnd_valid=1.
- WARMUP_CYCLES=2, req=4'b1111 held in SERVE → grants cycle 0001→0010→0100→1000→0001. Each rnd_out is the LFSR successor of the previous one, with no gaps.
- In SERVE, seed_load with seed_val=8'h4A and WARMUP_CYCLES=2 → no grant on the load edge, busy=1 for 2 cycles, next rnd_out=8'h2A.
- Single requester req[1] held continuously → gnt[1] pulses every second cycle and never in back-to-back cycles.
- seed_val=0 loaded → without macro, the sequence restarts from A5; with `QRNG_HEALTH_EN`, stuck_err=1, no grants, and a subsequent seed 8'h4A restores service with stuck_err still 1.
- rst_n pulsed low during active grants → gnt=0, rnd_valid=0, rnd_out=0 asynchronously; the sequence replays identically after release.

Source files
------------

// File: rtl/qrng_pkg.sv
// qrng_pkg: shared types and constants for the shared LFSR random source.
//   LFSR_W       - LFSR width (8)
//   TAP_MASK     - feedback taps for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
//   DEFAULT_SEED - reset seed and zero-seed substitute
//   state_e      - arbiter sequencing states (ST_FAULT used only with QRNG_HEALTH_EN)
package qrng_pkg;

  localparam int unsigned LFSR_W = 8;
  localparam logic [LFSR_W-1:0] TAP_MASK     = 8'hB8;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 8'hA5;

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_SERVE  = 2'd1,
    ST_FAULT  = 2'd2
  } state_e;

  // One LFSR advance: shift left, feedback is parity of the tapped bits.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & TAP_MASK)};
  endfunction

endpackage

// File: rtl/qrng_lfsr8_core.sv
// qrng_lfsr8_core: 8-bit maximal-length LFSR with load and step controls.
//   clk, rst_n - clock, async active-low reset (value <= SEED)
//   load       - reload value from load_val (has priority over step)
//   load_val   - value to load
//   step       - advance one LFSR step
//   value      - current LFSR state
module qrng_lfsr8_core
  import qrng_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              step,
  output logic [LFSR_W-1:0] value
);

  // LFSR state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= SEED;
    end else if (load) begin
      value <= load_val;
    end else if (step) begin
      value <= lfsr_step(value);
    end
  end

endmodule

// File: rtl/qrng_arbiter.sv
// qrng_arbiter: shares one 8-bit LFSR among NUM_REQ requesters, round-robin,
// one grant per cycle, each grant carrying the current (pre-advance) LFSR value.
//   clk, rst_n        - clock, async active-low reset
//   seed_load/seed_val- reseed pulse and value (priority over everything else)
//   req               - level requests, held until granted
//   gnt               - registered one-hot grant pulse
//   rnd_out/rnd_valid - random value for the grantee; valid exactly with gnt
//   busy              - source not in SERVE
//   stuck_err         - sticky health fault
// Optional feature: define QRNG_HEALTH_EN to reject zero seeds and enter FAULT;
// without it a zero seed is replaced by SEED and stuck_err is tied low.
module qrng_arbiter
  import qrng_pkg::*;
#(
  parameter int unsigned       NUM_REQ       = 4,
  parameter int unsigned       WARMUP_CYCLES = 16,
  parameter logic [LFSR_W-1:0] SEED          = DEFAULT_SEED
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               seed_load,
  input  logic [LFSR_W-1:0]  seed_val,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [LFSR_W-1:0]  rnd_out,
  output logic               rnd_valid,
  output logic               busy,
  output logic               stuck_err
);

  localparam int unsigned PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W    = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam int unsigned CNT_LAST = (WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0;
  localparam bit          WARMUP_EN = (WARMUP_CYCLES > 0);
`ifdef QRNG_HEALTH_EN
  localparam bit          HEALTH_EN = 1'b1;
`else
  localparam bit          HEALTH_EN = 1'b0;
`endif

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [PTR_W-1:0]   ptr;
  logic [LFSR_W-1:0]  lfsr;
  logic               lfsr_load;
  logic [LFSR_W-1:0]  lfsr_load_val;
  logic               lfsr_adv;
  logic               seed_reject;
  logic               lfsr_zero;
  logic [NUM_REQ-1:0] elig;
  logic               pick_found;
  logic [PTR_W-1:0]   pick_idx;
  int unsigned        scan_idx;

  qrng_lfsr8_core #(.SEED(SEED)) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lfsr_load),
    .load_val (lfsr_load_val),
    .step     (lfsr_adv),
    .value    (lfsr)
  );

  // LFSR control: seed load wins; otherwise advance in WARMUP and healthy SERVE.
  always_comb begin
    seed_reject   = HEALTH_EN && (seed_val == '0);
    lfsr_zero     = HEALTH_EN && (lfsr == '0);
    lfsr_load     = seed_load && !seed_reject;
    lfsr_load_val = (seed_val == '0) ? SEED : seed_val;
    lfsr_adv      = !seed_load &&
                    (((state == ST_WARMUP) && WARMUP_EN) ||
                     ((state == ST_SERVE) && !lfsr_zero));
  end

  // Round-robin pick: first eligible index after ptr, wrapping; last grantee masked.
  always_comb begin
    elig       = req & ~gnt;
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      scan_idx = (32'(ptr) + k) % NUM_REQ;
      if (!pick_found && elig[PTR_W'(scan_idx)]) begin
        pick_found = 1'b1;
        pick_idx   = PTR_W'(scan_idx);
      end
    end
  end

  // Sequencing FSM, warm-up counter, pointer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_WARMUP;
      cnt       <= '0;
      ptr       <= PTR_W'(NUM_REQ - 1);
      gnt       <= '0;
      rnd_out   <= '0;
      rnd_valid <= 1'b0;
      busy      <= 1'b1;
    end else begin
      gnt       <= '0;
      rnd_valid <= 1'b0;
      if (seed_load) begin
        cnt <= '0;
        if (seed_reject) begin
          state <= ST_FAULT;
          busy  <= 1'b1;
        end else if (WARMUP_EN) begin
          state <= ST_WARMUP;
          busy  <= 1'b1;
        end else begin
          state <= ST_SERVE;
          busy  <= 1'b0;
        end
      end else begin
        case (state)
          ST_WARMUP: begin
            if (!WARMUP_EN || (cnt == CNT_W'(CNT_LAST))) begin
              state <= ST_SERVE;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_SERVE: begin
            if (lfsr_zero) begin
              state <= ST_FAULT;
              busy  <= 1'b1;
            end else if (pick_found) begin
              gnt       <= NUM_REQ'(1) << pick_idx;
              rnd_out   <= lfsr;
              rnd_valid <= 1'b1;
              ptr       <= pick_idx;
            end
          end
          default: begin
            // FAULT: frozen until a non-zero seed load
          end
        endcase
      end
    end
  end

`ifdef QRNG_HEALTH_EN
  // Sticky health fault, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stuck_err <= 1'b0;
    end else if ((seed_load && seed_reject) ||
                 (!seed_load && (state == ST_SERVE) && lfsr_zero)) begin
      stuck_err <= 1'b1;
    end
  end
`else
  assign stuck_err = 1'b0;
`endif

endmodule
